// File: rtl/differentiator.sv
// differentiator: streaming comb stage y[n] = x[n] - x[n-M] with a registered output.
// Define DIFF_DECIMATE_EN to process only every DEC_R-th accepted sample.
module differentiator #(
    parameter int I_BW  = 8,
    parameter int O_BW  = 8,
    parameter int M     = 1,
    parameter int DEC_R = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic signed [I_BW-1:0] data_i,
    input  logic                   valid_i,
    output logic signed [O_BW-1:0] data_o,
    output logic                   valid_o
);
    if (M < 1 || M > 8 || DEC_R < 2 || DEC_R > 256) begin : g_bad_param
        $error("differentiator: M or DEC_R out of range");
    end
    logic signed [I_BW-1:0] dl_q [M];
    logic signed [I_BW-1:0] dl_d [M];
    logic signed [I_BW-1:0] diff;
    logic signed [O_BW-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   take;
`ifdef DIFF_DECIMATE_EN
    localparam int PW = $clog2(DEC_R);
    logic [PW-1:0] phase_q, phase_d;
    assign take = en_i & valid_i & (phase_q == '0);
    always_comb begin
        phase_d = !en_i ? '0 : !valid_i ? phase_q : phase_q == PW'(DEC_R - 1) ? '0 : phase_q + 1'b1;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) phase_q <= '0;
        else       phase_q <= phase_d;
    end
`else
    assign take = en_i & valid_i;
`endif
    // Wrapping subtraction lets integrator overflow cancel exactly.
    always_comb begin
        diff = data_i - dl_q[M-1];
        dl_d = dl_q;
        if (take) begin
            dl_d[0] = data_i;
            for (int k = 1; k < M; k++) dl_d[k] = dl_q[k-1];
        end
        if (!en_i) dl_d = '{default: '0};
        data_d  = !en_i ? '0 : take ? O_BW'(diff) : data_q;
        valid_d = take;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dl_q    <= '{default: '0};
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            dl_q    <= dl_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end
    assign data_o  = data_q;
    assign valid_o = valid_q;
endmodule
